// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. One full_adder is time-shared across WIDTH
//   bit positions, LSB first, one bit per clock. Operands are taken through a
//   valid/ready handshake and the result is offered through another one.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   CALC  | shifting one bit per clock through the full adder, busy=1
//   DONE  | result presented on sum/cout, out_valid=1 until out_ready
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, cin valid
//   in_ready   block can accept operands (state IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts result
//   sum        a+b+cin modulo 2^WIDTH, held until the next result
//   cout       carry out of bit WIDTH-1
//   busy       high while in CALC

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 14,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .in1  (a_sh[0]),
    .in2  (b_sh[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {fa_sum, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Result registers only change here, so sum/cout stay put in IDLE/CALC.
            sum_q   <= res_next;
            cout_q  <= fa_cout;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CALC);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 14;

  logic clk;
  logic rst_n;

  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  logic       iv2, ir2, ci2, ov2, or2, co2, bz2;
  logic [1:0] a2, b2, s2;

  logic        iv32, ir32, ci32, ov32, or32, co32, bz32;
  logic [31:0] a32, b32, s32;

  int vectors = 0;
  int errors  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .cin(ci2), .out_valid(ov2), .out_ready(or2),
    .sum(s2), .cout(co2), .busy(bz2)
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(ci32), .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32), .busy(bz32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the WIDTH=14 instance, with optional stall on out_ready.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int stall);
    logic [W:0] exp;
    int n;
    int busy_n;
    exp = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready_timeout in_ready=%b required 1", in_ready);
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0; busy_n = 0;
    while (!out_valid && n < 100) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    vectors++;
    if (n !== W) begin
      errors++;
      $display("FAIL op_latency edges=%0d required %0d (a=%0d b=%0d)", n, W, ta, tb_);
    end
    vectors++;
    if (busy_n !== W) begin
      errors++;
      $display("FAIL op_busy_cycles got %0d required %0d", busy_n, W);
    end
    vectors++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL op_result a=%0d b=%0d cin=%0d got cout=%0d sum=%0d required cout=%0d sum=%0d",
               ta, tb_, tc, cout, sum, exp[W], exp[W-1:0]);
    end
    for (int i = 0; i < stall; i++) tick();
    if (stall > 0) begin
      vectors++;
      if (!(out_valid === 1'b1 && {cout, sum} === exp)) begin
        errors++;
        $display("FAIL op_stall_hold out_valid=%b sum=%0d required 1/%0d", out_valid, sum,
                 exp[W-1:0]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
      errors++;
      $display("FAIL op_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
    iv2 = 0; a2 = '0; b2 = '0; ci2 = 0; or2 = 0;
    iv32 = 0; a32 = '0; b32 = '0; ci32 = 0; or32 = 0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({in_ready, busy, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state in_ready=%b busy=%b out_valid=%b cout=%b sum=%0d required 1/0/0/0/0",
               in_ready, busy, out_valid, cout, sum);
    end
    vectors++;
    if ({ir2, ov2, ir32, ov32} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_other_widths got %b required 1010", {ir2, ov2, ir32, ov32});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_corners();
    run_op(14'd9999, 14'd1, 1'b0, 0);
    run_op(14'd16383, 14'd1, 1'b0, 0);
    run_op(14'd0, 14'd0, 1'b1, 0);
    run_op(14'd16383, 14'd16383, 1'b1, 2);
  endtask

  task automatic test_backpressure();
    int n;
    a = 14'd1234; b = 14'd4321; cin = 0; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    a = 14'd7; b = 14'd8; cin = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (!(sum === 14'd5555 && cout === 1'b0 && out_valid === 1'b1 && in_ready === 1'b0)) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d sum=%0d out_valid=%b in_ready=%b required 5555/1/0",
                 i, sum, out_valid, in_ready);
      end
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    vectors++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0 && sum === 14'd5555)) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b sum=%0d required 1/0/5555",
               in_ready, out_valid, sum);
    end
    tick();
    in_valid = 0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_next busy=%b required 1", busy);
    end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    vectors++;
    if ({cout, sum} !== 15'd15) begin
      errors++;
      $display("FAIL bp_next_result sum=%0d required 15", sum);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset_midop();
    int n;
    a = 14'd5; b = 14'd7; cin = 0; in_valid = 1;
    tick();
    in_valid = 0;
    n = 1;
    while (n < 6) begin tick(); n++; end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, busy, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL midop_reset in_ready=%b busy=%b out_valid=%b cout=%b sum=%0d required 1/0/0/0/0",
               in_ready, busy, out_valid, cout, sum);
    end
    #3;
    rst_n = 1'b1;
    tick();
    run_op(14'd100, 14'd200, 1'b0, 0);
  endtask

  task automatic test_streaming();
    logic [W-1:0] op_a [3];
    logic [W-1:0] op_b [3];
    int idx_in, idx_out, last;
    op_a[0] = 14'd1;    op_b[0] = 14'd2;
    op_a[1] = 14'd3;    op_b[1] = 14'd4;
    op_a[2] = 14'd5000; op_b[2] = 14'd5000;
    idx_in = 0; idx_out = 0; last = 0;
    out_ready = 1; cin = 0;
    for (int cyc = 0; cyc < 200 && idx_out < 3; cyc++) begin
      if (in_ready && idx_in < 3) begin
        a = op_a[idx_in]; b = op_b[idx_in]; in_valid = 1; idx_in++;
      end
      tick();
      if (out_valid) begin
        vectors++;
        if ({cout, sum} !== ({1'b0, op_a[idx_out]} + {1'b0, op_b[idx_out]})) begin
          errors++;
          $display("FAIL stream_result idx=%0d sum=%0d required %0d", idx_out, sum,
                   op_a[idx_out] + op_b[idx_out]);
        end
        if (idx_out > 0) begin
          vectors++;
          if (cyc - last !== W + 2) begin
            errors++;
            $display("FAIL stream_spacing got %0d required %0d", cyc - last, W + 2);
          end
        end
        last = cyc;
        idx_out++;
      end
    end
    in_valid = 0;
    vectors++;
    if (idx_out !== 3) begin
      errors++;
      $display("FAIL stream_count got %0d required 3", idx_out);
    end
    tick();
    out_ready = 0;
  endtask

  task automatic test_random_w14();
    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
  endtask

  task automatic test_random_w2();
    int n;
    logic [1:0] ta, tb_;
    logic tc;
    logic [2:0] exp;
    for (int i = 0; i < 200; i++) begin
      ta = 2'($urandom); tb_ = 2'($urandom); tc = 1'($urandom);
      exp = {1'b0, ta} + {1'b0, tb_} + 3'(tc);
      a2 = ta; b2 = tb_; ci2 = tc; iv2 = 1;
      tick();
      iv2 = 0;
      n = 0;
      while (!ov2 && n < 50) begin tick(); n++; end
      vectors++;
      if (!(n == 2 && {co2, s2} === exp)) begin
        errors++;
        $display("FAIL w2_op a=%0d b=%0d cin=%0d got %0d after %0d edges required %0d after 2",
                 ta, tb_, tc, {co2, s2}, n, exp);
      end
      or2 = 1;
      tick();
      or2 = 0;
    end
  endtask

  task automatic test_random_w32();
    int n;
    logic [31:0] ta, tb_;
    logic tc;
    logic [32:0] exp;
    for (int i = 0; i < 200; i++) begin
      ta = $urandom; tb_ = $urandom; tc = 1'($urandom);
      if (i == 0) begin ta = 32'hFFFF_FFFF; tb_ = 32'hFFFF_FFFF; tc = 1; end
      exp = {1'b0, ta} + {1'b0, tb_} + 33'(tc);
      a32 = ta; b32 = tb_; ci32 = tc; iv32 = 1;
      tick();
      iv32 = 0;
      n = 0;
      while (!ov32 && n < 100) begin tick(); n++; end
      vectors++;
      if (!(n == 32 && {co32, s32} === exp)) begin
        errors++;
        $display("FAIL w32_op a=%0h b=%0h cin=%0d got %0h after %0d edges required %0h after 32",
                 ta, tb_, tc, {co32, s32}, n, exp);
      end
      or32 = 1;
      tick();
      or32 = 0;
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_backpressure();
    test_reset_midop();
    test_streaming();
    test_random_w14();
    test_random_w2();
    test_random_w32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
